j1708_rx_frame_scheduler: RTL and testbench
===========================================

// Module: j1708_rx_frame_scheduler
// PURPOSE
//  Sequences transfer of received J1708 messages from the J1708 receive buffers to the CPU UART tx path.
//  Pops one message length, then pops that many payload bytes, paced by UART busy.
//  Emits each message as one frame: SOF, LEN, payload, CSUM. Replaces the ungated byte_read = new_byte & ~busy path.
//  Sits between J1708_TOP (rx length/byte interfaces) and MCU_INTERFACE (uart_tx_data_in/wr/busy).
// PARAMETERS
//  CLK_FRQ_MHZ      26      clock frequency, MHz
//  SOF_BYTE         8'hA5   frame start marker
//  MAX_LEN          21      largest legal J1708 message length, bytes
//  BYTE_TIMEOUT_US  2000    max wait for len_valid/byte_valid; TO_CYC = CLK_FRQ_MHZ*BYTE_TIMEOUT_US
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous, active-low reset
//  enable       in   1  forwarding enable (J1708_enable)
//  len_exist    in   1  rx length FIFO non-empty
//  len_read     out  1  1-cycle pop of rx length FIFO
//  len          in   8  popped length; qualified by len_valid
//  len_valid    in   1  length data valid (>=1 cycle after len_read)
//  byte_read    out  1  1-cycle pop of rx byte FIFO
//  byte_in      in   8  popped payload byte; qualified by byte_valid
//  byte_valid   in   1  byte data valid (>=1 cycle after byte_read)
//  uart_busy    in   1  CPU UART transmitter busy
//  uart_data    out  8  byte to CPU UART
//  uart_wr      out  1  1-cycle UART write strobe
//  frame_done   out  1  1-cycle pulse, frame fully sent
//  frame_error  out  1  1-cycle pulse, frame dropped or truncated
//  busy         out  1  high whenever state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all outputs 0; checksum, counters 0; in-flight frame abandoned.
//  States: IDLE, POP_LEN, WAIT_LEN, SEND_SOF, SEND_LEN, POP_BYTE, WAIT_BYTE, SEND_BYTE, SEND_CSUM, DISCARD.
//  IDLE: enable & len_exist -> POP_LEN. len_read is registered and high exactly 1 cycle.
//  WAIT_LEN on len_valid, by captured len:
//   len==0 -> frame_error, back to IDLE; no pops, no UART writes.
//   len>MAX_LEN -> DISCARD: pop len bytes with read/valid handshake, no UART writes, then frame_error -> IDLE.
//   otherwise -> SEND_SOF.
//  UART rule: uart_wr only in a cycle with uart_busy==0.
//   The cycle after each uart_wr is a guard cycle in which uart_busy is ignored.
//   Then wait for uart_busy==0 before the next write. uart_data holds until the next uart_wr.
//  SEND_SOF writes SOF_BYTE; SEND_LEN writes len.
//  Per payload byte: POP_BYTE (byte_read) -> WAIT_BYTE -> SEND_BYTE (write byte_in). Repeat len times.
//  SEND_CSUM writes CSUM = -(len + sum payload) mod 256, 8-bit wrap, so LEN+payload+CSUM == 0 mod 256.
//   frame_done pulses in the cycle of the CSUM uart_wr; next state IDLE.
//  Single outstanding pop: never issue len_read/byte_read while a previous pop awaits valid.
//  Timeout: counter clears on each pop and counts while in WAIT_LEN/WAIT_BYTE/DISCARD-wait.
//   Reaching TO_CYC -> frame_error, IDLE. If SOF was already sent the frame is truncated; CPU detects via CSUM.
//  enable falling: blocks only IDLE->POP_LEN; a frame in progress completes normally.
//  len_exist high on the frame_done/error cycle: next frame starts on the following cycle (no idle gap beyond IDLE).
//  Payload counter 5 bits min (covers MAX_LEN); timeout counter $clog2(TO_CYC)+1 bits.
// TESTING
//  len=3, bytes 10,20,30, busy=0 -> uart A5,03,10,20,30,9D; 3 byte_read; frame_done x1; no error
//  same frame, uart_busy held 1 for 100 cycles after SOF -> no uart_wr while busy; identical byte sequence
//  len=0 -> frame_error x1; zero uart_wr; zero byte_read; busy back to 0 within 4 cycles
//  len=25 -> 25 byte_read pulses, zero uart_wr, frame_error x1; next legal frame forwards correctly
//  len=2, byte_valid withheld -> frame_error at TO_CYC cycles after byte_read; IDLE; no frame_done
//  rst=0 mid-payload -> outputs 0 immediately (async); after release, next frame begins with A5; enable=0 blocks start

Source files
------------

// File: rtl/j1708_rx_frame_scheduler.sv
// Moves received J1708 messages from the rx length/byte FIFOs to the CPU UART.
// Each message is sent as one frame: SOF, LEN, payload, CSUM. Pops and writes are paced.
module j1708_rx_frame_scheduler #(
  parameter int          CLK_FRQ_MHZ     = 26,
  parameter logic [7:0]  SOF_BYTE        = 8'hA5,
  parameter int          MAX_LEN         = 21,
  parameter int          BYTE_TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       len_exist,
  output logic       len_read,
  input  logic [7:0] len,
  input  logic       len_valid,
  output logic       byte_read,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       uart_busy,
  output logic [7:0] uart_data,
  output logic       uart_wr,
  output logic       frame_done,
  output logic       frame_error,
  output logic       busy
);

  localparam int TO_CYC = CLK_FRQ_MHZ * BYTE_TIMEOUT_US;
  localparam int TW     = $clog2(TO_CYC) + 1;

  typedef enum logic [3:0] {
    IDLE, POP_LEN, WAIT_LEN, SEND_SOF, SEND_LEN,
    POP_BYTE, WAIT_BYTE, SEND_BYTE, SEND_CSUM, DISCARD
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      byte_q, byte_d;
  logic [7:0]      data_q, data_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            len_read_q, len_read_d;
  logic            byte_read_q, byte_read_d;
  logic            guard_q, guard_d;
  logic            pend_q, pend_d;
  logic            wr;
  logic [7:0]      wr_byte;
  logic            done;
  logic            err;
  logic            tx_ok;
  logic            tmo_hit;

  // The cycle after a write is a guard cycle: the UART's busy flag may not yet reflect it.
  assign tx_ok   = ~guard_q & ~uart_busy;
  assign tmo_hit = (tmo_q == TW'(TO_CYC));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    byte_d      = byte_q;
    tmo_d       = tmo_q;
    pend_d      = pend_q;
    len_read_d  = 1'b0;
    byte_read_d = 1'b0;
    wr          = 1'b0;
    wr_byte     = byte_q;
    done        = 1'b0;
    err         = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && len_exist) state_d = POP_LEN;
      end
      POP_LEN: begin
        len_read_d = 1'b1;
        tmo_d      = '0;
        state_d    = WAIT_LEN;
      end
      WAIT_LEN: begin
        // Valid is only trusted once the pop strobe itself has gone low.
        if (len_valid && !len_read_q) begin
          len_d  = len;
          sum_d  = len;
          cnt_d  = '0;
          pend_d = 1'b0;
          if (len == 8'd0) begin
            err     = 1'b1;
            state_d = IDLE;
          end else if (len > 8'(MAX_LEN)) begin
            state_d = DISCARD;
          end else begin
            state_d = SEND_SOF;
          end
        end else if (tmo_hit) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      SEND_SOF: begin
        wr_byte = SOF_BYTE;
        if (tx_ok) begin
          wr      = 1'b1;
          state_d = SEND_LEN;
        end
      end
      SEND_LEN: begin
        wr_byte = len_q;
        if (tx_ok) begin
          wr      = 1'b1;
          state_d = POP_BYTE;
        end
      end
      POP_BYTE: begin
        byte_read_d = 1'b1;
        tmo_d       = '0;
        state_d     = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        if (byte_valid && !byte_read_q) begin
          byte_d  = byte_in;
          sum_d   = sum_q + byte_in;
          state_d = SEND_BYTE;
        end else if (tmo_hit) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      SEND_BYTE: begin
        wr_byte = byte_q;
        if (tx_ok) begin
          wr      = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          state_d = ((cnt_q + 8'd1) == len_q) ? SEND_CSUM : POP_BYTE;
        end
      end
      SEND_CSUM: begin
        wr_byte = ~sum_q + 8'd1;
        if (tx_ok) begin
          wr      = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      DISCARD: begin
        // Oversize message: drain its bytes one handshake at a time without forwarding.
        if (!pend_q) begin
          if (cnt_q == len_q) begin
            err     = 1'b1;
            state_d = IDLE;
          end else begin
            byte_read_d = 1'b1;
            pend_d      = 1'b1;
            tmo_d       = '0;
          end
        end else if (byte_valid && !byte_read_q) begin
          pend_d = 1'b0;
          cnt_d  = cnt_q + 8'd1;
        end else if (tmo_hit) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    guard_d = wr;
    data_d  = wr ? wr_byte : data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      byte_q      <= '0;
      data_q      <= '0;
      tmo_q       <= '0;
      len_read_q  <= 1'b0;
      byte_read_q <= 1'b0;
      guard_q     <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      byte_q      <= byte_d;
      data_q      <= data_d;
      tmo_q       <= tmo_d;
      len_read_q  <= len_read_d;
      byte_read_q <= byte_read_d;
      guard_q     <= guard_d;
      pend_q      <= pend_d;
    end
  end

  assign len_read    = len_read_q;
  assign byte_read   = byte_read_q;
  assign uart_wr     = wr;
  assign uart_data   = wr ? wr_byte : data_q;
  assign frame_done  = done;
  assign frame_error = err;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_j1708_rx_frame_scheduler.sv
// Directed bench for j1708_rx_frame_scheduler: FIFO responder, UART monitor, hand-computed frames.
module tb_j1708_rx_frame_scheduler;

  localparam int TO_CYC = 26 * 2;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       len_exist;
  logic       len_read;
  logic [7:0] len;
  logic       len_valid;
  logic       byte_read;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       uart_busy;
  logic [7:0] uart_data;
  logic       uart_wr;
  logic       frame_done;
  logic       frame_error;
  logic       busy;

  j1708_rx_frame_scheduler #(
    .CLK_FRQ_MHZ    (26),
    .SOF_BYTE       (8'hA5),
    .MAX_LEN        (21),
    .BYTE_TIMEOUT_US(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .len_exist  (len_exist),
    .len_read   (len_read),
    .len        (len),
    .len_valid  (len_valid),
    .byte_read  (byte_read),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .uart_busy  (uart_busy),
    .uart_data  (uart_data),
    .uart_wr    (uart_wr),
    .frame_done (frame_done),
    .frame_error(frame_error),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] byte_src [0:31];
  int         byte_idx    = 0;
  logic [7:0] cfg_len     = 8'd0;
  int         frames_left = 0;
  logic       withhold    = 1'b0;
  logic       len_pend    = 1'b0;
  logic       byte_pend   = 1'b0;
  logic [7:0] wr_log [$];
  logic [7:0] exp_q  [$];
  int         n_len_read = 0, n_byte_read = 0, n_done = 0, n_err = 0, busy_viol = 0;
  int         cyc = 0, err_cycle = 0, br_cycle = 0;

  // FIFO model: data becomes valid one cycle after the pop strobe is seen.
  always @(posedge clk) begin
    #1;
    len_valid  = 1'b0;
    byte_valid = 1'b0;
    if (!rst) begin
      len_pend  = 1'b0;
      byte_pend = 1'b0;
    end else begin
      if (len_pend) begin
        len_valid = 1'b1;
        len       = cfg_len;
        len_pend  = 1'b0;
      end
      if (byte_pend) begin
        if (!withhold) begin
          byte_valid = 1'b1;
          byte_in    = byte_src[byte_idx];
          byte_idx++;
        end
        byte_pend = 1'b0;
      end
      if (len_read) begin
        len_pend = 1'b1;
        if (frames_left > 0) frames_left--;
      end
      if (byte_read) byte_pend = 1'b1;
    end
    len_exist = (frames_left != 0);
  end

  always @(negedge clk) begin
    if (uart_wr) begin
      wr_log.push_back(uart_data);
      $display("uart_wr data=%02h busy=%0b cyc=%0d", uart_data, uart_busy, cyc);
      if (uart_busy) busy_viol++;
    end
    if (len_read) n_len_read++;
    if (byte_read) begin
      n_byte_read++;
      br_cycle = cyc;
    end
    if (frame_done) n_done++;
    if (frame_error) begin
      n_err++;
      err_cycle = cyc;
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] l);
    wr_log.delete();
    n_len_read = 0; n_byte_read = 0; n_done = 0; n_err = 0; busy_viol = 0;
    byte_idx    = 0;
    cfg_len     = l;
    frames_left = 1;
  endtask

  task automatic wait_frame(input string tag, input int budget);
    int k;
    k = 0;
    while (!(((n_done + n_err) > 0) && !busy) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_end_in_budget"}, 32'(k < budget), 32'd1);
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (wr_log.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_writes_in_budget"}, 32'(k < budget), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_nwr"}, 32'(wr_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(wr_log[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    rst       = 1'b0;
    enable    = 1'b0;
    uart_busy = 1'b0;
    len       = 8'd0;
    byte_in   = 8'd0;
    len_valid = 1'b0;
    byte_valid = 1'b0;
    len_exist = 1'b0;
    for (int i = 0; i < 32; i++) byte_src[i] = 8'(i);

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {31'd0, len_read | byte_read | uart_wr | frame_done | frame_error | busy}, 32'd0);
    check("reset_data", 32'(uart_data), 32'd0);
    rst    = 1'b1;
    enable = 1'b1;

    // Basic frame: 3 payload bytes, UART always ready.
    byte_src[0] = 8'h10; byte_src[1] = 8'h20; byte_src[2] = 8'h30;
    start_frame(8'd3);
    wait_frame("basic", 200);
    exp_q = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h9D};
    check_frame("basic");
    check("basic_len_reads", 32'(n_len_read), 32'd1);
    check("basic_byte_reads", 32'(n_byte_read), 32'd3);
    check("basic_done", 32'(n_done), 32'd1);
    check("basic_err", 32'(n_err), 32'd0);
    check("basic_busy_viol", 32'(busy_viol), 32'd0);

    // Same frame, UART busy for 100 cycles after SOF.
    start_frame(8'd3);
    wait_writes("busyhold", 1, 50);
    uart_busy = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("busyhold_no_wr_while_busy", 32'(wr_log.size()), 32'd1);
    uart_busy = 1'b0;
    wait_frame("busyhold", 200);
    check_frame("busyhold");
    check("busyhold_busy_viol", 32'(busy_viol), 32'd0);
    check("busyhold_done", 32'(n_done), 32'd1);

    // Zero-length message is dropped.
    start_frame(8'd0);
    wait_frame("len0", 50);
    check("len0_err", 32'(n_err), 32'd1);
    check("len0_nwr", 32'(wr_log.size()), 32'd0);
    check("len0_byte_reads", 32'(n_byte_read), 32'd0);
    check("len0_done", 32'(n_done), 32'd0);
    check("len0_idle_within_4", 32'((cyc - err_cycle) <= 4), 32'd1);

    // Oversize message is drained silently.
    start_frame(8'd25);
    wait_frame("len25", 500);
    check("len25_byte_reads", 32'(n_byte_read), 32'd25);
    check("len25_nwr", 32'(wr_log.size()), 32'd0);
    check("len25_err", 32'(n_err), 32'd1);
    check("len25_done", 32'(n_done), 32'd0);

    byte_src[0] = 8'h01; byte_src[1] = 8'h02;
    start_frame(8'd2);
    wait_frame("after25", 200);
    exp_q = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'hFB};
    check_frame("after25");
    check("after25_done", 32'(n_done), 32'd1);

    // Byte never arrives: truncated frame, timeout error.
    withhold = 1'b1;
    start_frame(8'd2);
    wait_frame("timeout", 300);
    withhold = 1'b0;
    exp_q = '{8'hA5, 8'h02};
    check_frame("timeout");
    check("timeout_byte_reads", 32'(n_byte_read), 32'd1);
    check("timeout_err", 32'(n_err), 32'd1);
    check("timeout_done", 32'(n_done), 32'd0);
    check("timeout_latency", 32'(err_cycle - br_cycle), 32'(TO_CYC));
    check("timeout_idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a payload.
    byte_src[0] = 8'h10; byte_src[1] = 8'h20; byte_src[2] = 8'h30;
    start_frame(8'd3);
    wait_writes("rst", 3, 100);
    #3;
    rst = 1'b0;
    #1;
    check("rst_async_ctrl", {26'd0, len_read, byte_read, uart_wr, frame_done, frame_error, busy}, 32'd0);
    check("rst_async_data", 32'(uart_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    byte_src[0] = 8'h01; byte_src[1] = 8'h02;
    start_frame(8'd2);
    wait_frame("afterrst", 200);
    exp_q = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'hFB};
    check_frame("afterrst");

    // enable low blocks a new frame.
    enable = 1'b0;
    start_frame(8'd2);
    repeat (20) @(posedge clk);
    #1;
    check("disabled_len_reads", 32'(n_len_read), 32'd0);
    check("disabled_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
